// File: rtl/fifo_push_arb_pkg.sv
// Shared types and elaboration helpers for the FIFO push arbiter.
// The arbiter parameters live on the top module; these helpers derive the
// dependent widths so every file agrees on them.
package fifo_arb_pkg;

    // Defaults used by the top module's parameter list.
    localparam int N_REQ_DEFAULT     = 4;
    localparam int WIDTH_DEFAULT     = 4;
    localparam int MAX_BURST_DEFAULT = 4;

    // Arbiter FSM: IDLE has no owner, BURST has a registered owner moving beats.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Width of a requester index. Clamped to 1 so a degenerate N_REQ still elaborates.
    function automatic int id_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    // Width of the beat counter; wide enough to hold MAX_BURST itself.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    // Wrap an index in 0..2n-1 back into 0..n-1. Works for any n, not just powers of two.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/fifo_push_arb_rr_picker.sv
// Combinational round-robin priority encoder.
// Scans the request vector starting one past last_winner and wrapping modulo
// N_REQ; the first set bit found is the winner.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEFAULT,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_winner,
    output logic [ID_W-1:0]  winner,
    output logic             any_req
);

    logic [ID_W-1:0] cand;

    // Rotating scan: candidate i steps through last_winner+1 .. last_winner+N_REQ.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = ID_W'(rr_wrap(int'(last_winner) + i, N_REQ));
            if (!any_req && req[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arb.sv
// Round-robin push arbiter in front of a single FIFO write port.
//
// Handshake: a requester beat transfers on a rising clk edge where
// req_valid[i] && req_ready[i] are both high; that same cycle fifo_push is
// high and fifo_data carries the beat. A requester holding valid must keep
// data/last stable until it sees ready, because nothing is buffered here.
// req_ready only ever rises for the current owner and only while the FIFO
// is not full, so at most one bit is set.
//
// An owner keeps the grant until it sends a beat marked last, reaches
// MAX_BURST beats, or drops valid while the FIFO could have accepted. A full
// FIFO stalls the owner indefinitely without losing the grant. Every burst is
// followed by one IDLE cycle in which the next owner is picked.
module fifo_push_arb
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ     = N_REQ_DEFAULT,
    parameter  int WIDTH     = WIDTH_DEFAULT,
    parameter  int MAX_BURST = MAX_BURST_DEFAULT,
    localparam int ID_W      = id_width(N_REQ),
    localparam int CNT_W     = cnt_width(MAX_BURST)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_push,
    output logic [WIDTH-1:0]            fifo_data,
    output logic [ID_W-1:0]             grant_id,
    output logic                        busy
);

    // Beat index of the final beat a burst may carry.
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    // Reset value chosen so requester 0 is first in the search order.
    localparam logic [ID_W-1:0]  LW_RESET  = ID_W'(N_REQ - 1);

    arb_state_t       state;
    arb_state_t       next_state;
    logic [ID_W-1:0]  owner;
    logic [ID_W-1:0]  last_winner;
    logic [CNT_W-1:0] beat_cnt;

    logic [ID_W-1:0]  pick_id;
    logic             pick_any;
    logic             own_valid;
    logic             own_last;
    logic             beat_accept;
    logic             cnt_at_max;
    logic             burst_end;

    rr_picker #(
        .N_REQ       (N_REQ)
    ) u_picker (
        .req         (req_valid),
        .last_winner (last_winner),
        .winner      (pick_id),
        .any_req     (pick_any)
    );

    assign own_valid   = req_valid[owner];
    assign own_last    = req_last[owner];
    assign beat_accept = (state == BURST) && own_valid && !fifo_full;
    assign cnt_at_max  = (beat_cnt == LAST_BEAT);

    // The burst closes on a final accepted beat, or when the owner goes quiet
    // in a cycle where the FIFO had room (a full FIFO never ends a burst).
    assign burst_end = (state == BURST) &&
                       ((beat_accept && (own_last || cnt_at_max)) ||
                        (!own_valid && !fifo_full));

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: grant on any request, release on burst end.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (pick_any)  next_state = BURST;
            BURST:   if (burst_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Owner, round-robin pointer and beat counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner       <= '0;
            last_winner <= LW_RESET;
            beat_cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner    <= pick_id;
                        beat_cnt <= '0;
                    end
                end
                BURST: begin
                    if (burst_end) begin
                        last_winner <= owner;
                        beat_cnt    <= '0;
                    end else if (beat_accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    beat_cnt <= '0;
                end
            endcase
        end
    end

    // Outputs: straight from the registered owner with no extra pipeline stage.
    always_comb begin
        req_ready = '0;
        fifo_push = 1'b0;
        fifo_data = '0;
        grant_id  = '0;
        busy      = 1'b0;
        if (state == BURST) begin
            busy             = 1'b1;
            grant_id         = owner;
            req_ready[owner] = !fifo_full;
            fifo_push        = beat_accept;
            if (beat_accept) begin
                fifo_data = req_data[owner];
            end
        end
    end

endmodule

// File: tb/tb_fifo_push_arb.sv
// Directed testbench for fifo_push_arb: one 4-requester instance covering
// grant, burst length, stall, release and async reset; one 3-requester
// instance covering the non-power-of-two wrap.
module tb_fifo_push_arb;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int MB = 4;
    localparam int DEPTH = 32;

    // Clock/reset
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // 4-requester DUT
    logic [N-1:0]        req_valid;
    logic [N-1:0][W-1:0] req_data;
    logic [N-1:0]        req_last;
    logic [N-1:0]        req_ready;
    logic                fifo_full;
    logic                fifo_push;
    logic [W-1:0]        fifo_data;
    logic [1:0]          grant_id;
    logic                busy;

    // 3-requester DUT
    logic [2:0]          r3_valid;
    logic [2:0][W-1:0]   r3_data;
    logic [2:0]          r3_last;
    logic [2:0]          r3_ready;
    logic                r3_full;
    logic                r3_push;
    logic [W-1:0]        r3_fdata;
    logic [1:0]          r3_grant;
    logic                r3_busy;

    fifo_push_arb #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_push (fifo_push),
        .fifo_data (fifo_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    fifo_push_arb #(.N_REQ(3), .WIDTH(W), .MAX_BURST(MB)) dut3 (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (r3_valid),
        .req_data  (r3_data),
        .req_last  (r3_last),
        .req_ready (r3_ready),
        .fifo_full (r3_full),
        .fifo_push (r3_push),
        .fifo_data (r3_fdata),
        .grant_id  (r3_grant),
        .busy      (r3_busy)
    );

    // Requester beat sources: {last, data} per entry, read pointer advances on accept.
    logic [W:0]   src_mem [N][DEPTH];
    int           src_rd  [N];
    int           src_wr  [N];
    logic [N-1:0] src_en;
    logic [N-1:0] fire;

    // Scoreboard
    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            if (src_en[i] && (src_rd[i] < src_wr[i])) begin
                req_valid[i] = 1'b1;
                req_data[i]  = src_mem[i][src_rd[i]][W-1:0];
                req_last[i]  = src_mem[i][src_rd[i]][W];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i]  = '0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic add_beat(input int r, input logic [W-1:0] d, input logic last);
        src_mem[r][src_wr[r]] = {last, d};
        src_wr[r]++;
    endtask

    task automatic clear_sources();
        src_en    = '0;
        fire      = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        drive_sources();
        r3_valid = '0;
        r3_data  = '0;
        r3_last  = '0;
        r3_full  = 1'b0;
    endtask

    // Negedge: note handshakes and score any push.
    task automatic sample();
        @(negedge clk);
        fire = req_valid & req_ready;
        if (fifo_push) begin
            if (exp_q.size() == 0) check("push_unexpected", {31'b0, fifo_push}, 32'd0);
            else                   check("push_data", {28'b0, fifo_data}, {28'b0, exp_q.pop_front()});
        end
    endtask

    // Just after posedge: retire accepted beats and present the next ones.
    task automatic advance();
        @(posedge clk);
        #1;
        if (rstn) begin
            for (int i = 0; i < N; i++) if (fire[i]) src_rd[i]++;
        end
        fire = '0;
        drive_sources();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_sources();
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};
    int g;
    logic eb;

    initial begin
        // ---------------- reset values ----------------
        clear_sources();
        rstn = 1'b0;
        @(negedge clk);
        check("rst_ready", {28'b0, req_ready}, 32'd0);
        check("rst_push",  {31'b0, fifo_push}, 32'd0);
        check("rst_data",  {28'b0, fifo_data}, 32'd0);
        check("rst_grant", {30'b0, grant_id},  32'd0);
        check("rst_busy",  {31'b0, busy},      32'd0);
        check("rst3_busy", {31'b0, r3_busy},   32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // ---------------- 1: single requester 2, A,B,C ----------------
        add_beat(2, 4'hA, 1'b0); add_beat(2, 4'hB, 1'b0); add_beat(2, 4'hC, 1'b1);
        exp_q.push_back(4'hA); exp_q.push_back(4'hB); exp_q.push_back(4'hC);
        src_en[2] = 1'b1;
        drive_sources();
        sample(); check("t1_idle_busy", {31'b0, busy}, 32'd0); advance();
        sample();
        check("t1_grant", {30'b0, grant_id},  32'd2);
        check("t1_ready", {28'b0, req_ready}, 32'h4);
        check("t1_busy",  {31'b0, busy},      32'd1);
        advance();
        sample(); check("t1_push_b", {31'b0, fifo_push}, 32'd1); advance();
        sample(); check("t1_push_c", {31'b0, fifo_push}, 32'd1); check("t1_busy_c", {31'b0, busy}, 32'd1); advance();
        sample(); check("t1_end_busy", {31'b0, busy}, 32'd0); check("t1_end_push", {31'b0, fifo_push}, 32'd0); advance();
        check("t1_sb_empty", exp_q.size(), 32'd0);

        // ---------------- 2: all valid, MAX_BURST cuts bursts ----------------
        do_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 8; k++) add_beat(i, W'((i * 5 + k) & 15), 1'b0);
        for (int gi = 0; gi < 5; gi++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(W'((order[gi] * 5 + ((gi == 4) ? 4 + b : b)) & 15));
        src_en = 4'hF;
        drive_sources();
        for (int k = 0; k < 25; k++) begin
            sample();
            eb = ((k % 5) != 0);
            check("t2_busy", {31'b0, busy},      {31'b0, eb});
            check("t2_push", {31'b0, fifo_push}, {31'b0, eb});
            if (eb) check("t2_grant", {30'b0, grant_id}, order[k / 5]);
            advance();
        end
        check("t2_sb_empty", exp_q.size(), 32'd0);

        // ---------------- 3: fifo_full stall mid-burst ----------------
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            add_beat(1, W'(k), 1'b0);
            exp_q.push_back(W'(k));
        end
        src_en[1] = 1'b1;
        drive_sources();
        sample(); check("t3_idle", {31'b0, busy}, 32'd0); advance();
        sample(); check("t3_grant", {30'b0, grant_id}, 32'd1); advance();
        sample(); advance();
        fifo_full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            sample();
            check("t3_stall_push",  {31'b0, fifo_push}, 32'd0);
            check("t3_stall_ready", {28'b0, req_ready}, 32'd0);
            check("t3_stall_busy",  {31'b0, busy},      32'd1);
            check("t3_stall_grant", {30'b0, grant_id},  32'd1);
            advance();
        end
        fifo_full = 1'b0;
        sample(); check("t3_resume3", {31'b0, fifo_push}, 32'd1); advance();
        sample(); check("t3_resume4", {31'b0, fifo_push}, 32'd1); advance();
        sample(); check("t3_cnt_end", {31'b0, busy}, 32'd0); advance();
        sample(); check("t3_regrant", {31'b0, busy}, 32'd1); check("t3_push5", {31'b0, fifo_push}, 32'd1); advance();
        sample();
        check("t3_drop_busy",  {31'b0, busy},      32'd1);
        check("t3_drop_push",  {31'b0, fifo_push}, 32'd0);
        check("t3_drop_ready", {28'b0, req_ready}, 32'h2);
        advance();
        sample(); check("t3_released", {31'b0, busy}, 32'd0); advance();
        check("t3_sb_empty", exp_q.size(), 32'd0);

        // ---------------- 4: owner 3 idles, pointer moves past it ----------------
        do_reset();
        add_beat(1, 4'h7, 1'b1);
        add_beat(3, 4'h8, 1'b0); add_beat(3, 4'h9, 1'b0);
        exp_q.push_back(4'h7); exp_q.push_back(4'h8); exp_q.push_back(4'h9);
        exp_q.push_back(4'hD); exp_q.push_back(4'hE);
        src_en = 4'b1010;
        drive_sources();
        sample(); check("t4_idle0", {31'b0, busy}, 32'd0); advance();
        sample(); check("t4_grant1", {30'b0, grant_id}, 32'd1); check("t4_push7", {31'b0, fifo_push}, 32'd1); advance();
        sample(); check("t4_gap", {31'b0, busy}, 32'd0); advance();
        sample(); check("t4_grant3", {30'b0, grant_id}, 32'd3); advance();
        sample(); advance();
        add_beat(0, 4'hD, 1'b1); add_beat(2, 4'hE, 1'b1);
        src_en = 4'b1111;
        drive_sources();
        sample();
        check("t4_drop_busy",  {31'b0, busy},      32'd1);
        check("t4_drop_push",  {31'b0, fifo_push}, 32'd0);
        check("t4_drop_ready", {28'b0, req_ready}, 32'h8);
        advance();
        sample(); check("t4_gap2", {31'b0, busy}, 32'd0); advance();
        sample(); check("t4_grant0", {30'b0, grant_id}, 32'd0); check("t4_pushD", {31'b0, fifo_push}, 32'd1); advance();
        sample(); check("t4_gap3", {31'b0, busy}, 32'd0); advance();
        sample(); check("t4_grant2", {30'b0, grant_id}, 32'd2); advance();
        sample(); check("t4_idle_end", {31'b0, busy}, 32'd0); advance();
        check("t4_sb_empty", exp_q.size(), 32'd0);

        // ---------------- 5: async reset during second beat ----------------
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            add_beat(0, W'(k), 1'b0);
            exp_q.push_back(W'(k));
        end
        src_en[0] = 1'b1;
        drive_sources();
        sample(); check("t5_idle", {31'b0, busy}, 32'd0); advance();
        sample(); check("t5_grant0", {30'b0, grant_id}, 32'd0); check("t5_push1", {31'b0, fifo_push}, 32'd1); advance();
        #1;
        check("t5_pre_rst_push", {31'b0, fifo_push}, 32'd1);
        rstn = 1'b0;
        #1;
        check("t5_rst_push",  {31'b0, fifo_push}, 32'd0);
        check("t5_rst_ready", {28'b0, req_ready}, 32'd0);
        check("t5_rst_busy",  {31'b0, busy},      32'd0);
        check("t5_rst_data",  {28'b0, fifo_data}, 32'd0);
        sample(); advance();
        rstn = 1'b1;
        sample(); check("t5_post_idle", {31'b0, busy}, 32'd0); advance();
        sample(); check("t5_regrant0", {30'b0, grant_id}, 32'd0); check("t5_repush", {31'b0, fifo_push}, 32'd1); advance();
        sample(); advance();
        sample(); advance();
        sample(); check("t5_4th_busy", {31'b0, busy}, 32'd1); check("t5_4th_push", {31'b0, fifo_push}, 32'd1); advance();
        sample(); check("t5_cnt_end", {31'b0, busy}, 32'd0); advance();
        sample(); check("t5_push6", {31'b0, fifo_push}, 32'd1); advance();
        sample(); check("t5_drop_busy", {31'b0, busy}, 32'd1); check("t5_drop_push", {31'b0, fifo_push}, 32'd0); advance();
        sample(); check("t5_released", {31'b0, busy}, 32'd0); advance();
        check("t5_sb_empty", exp_q.size(), 32'd0);

        // ---------------- 6: N_REQ=3, requesters 0 and 2 alternate ----------------
        do_reset();
        r3_valid   = 3'b101;
        r3_last    = 3'b101;
        r3_data[0] = 4'h5;
        r3_data[1] = 4'hF;
        r3_data[2] = 4'hA;
        for (int k = 0; k < 9; k++) begin
            sample();
            if ((k % 2) == 0) begin
                check("t6_idle_busy", {31'b0, r3_busy}, 32'd0);
                check("t6_idle_push", {31'b0, r3_push}, 32'd0);
            end else begin
                g = ((k % 4) == 1) ? 0 : 2;
                check("t6_grant", {30'b0, r3_grant}, g);
                check("t6_ready", {29'b0, r3_ready}, 32'd1 << g);
                check("t6_push",  {31'b0, r3_push},  32'd1);
                check("t6_data",  {28'b0, r3_fdata}, (g == 0) ? 32'h5 : 32'hA);
            end
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the directed sequence is a few hundred cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
